// File: rtl/scratch_mem_arbiter.sv
// rtl/scratch_mem_arbiter.sv - round-robin arbiter with locked bursts and test override for the scratch memory
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   req/req_lock/req_we   per-requester request, keep-ownership and write flags
//   req_addr/req_wdata    packed per-requester address and write data
//   gnt                   one-hot combinational grant
//   rvalid/rdata          registered read-valid strobe, read data from memory
//   test_*                test port, overrides all requesters while test_en=1
//   mem_*                 simple dual-port memory interface (1-cycle read latency)
//   locked/lock_timeout   LOCK state flag, one-cycle pulse on forced lock release
module scratch_mem_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  input  logic               test_en,
  input  logic               test_we,
  input  logic [AW-1:0]      test_waddr,
  input  logic [AW-1:0]      test_raddr,
  input  logic [DW-1:0]      test_wdata,
  output logic [AW-1:0]      mem_waddr,
  output logic [DW-1:0]      mem_din,
  output logic               mem_we,
  output logic [AW-1:0]      mem_raddr,
  input  logic [DW-1:0]      mem_dout,
  output logic               locked,
  output logic               lock_timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);
  // Last LOCK cycle value of the counter: the ARB cycle that took the lock
  // counts as access 1, so MAX_LOCK grants in total before forced release.
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {ST_ARB, ST_LOCK, ST_TEST} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr, rr_nx;
  logic [IW-1:0]   owner, owner_nx;
  logic [CW-1:0]   lock_cnt, cnt_nx;
  logic            timeout_nx;
  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;

  function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] p);
    inc_ptr = (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    int  idx;
    logic found;
    state_nx   = state;
    rr_nx      = rr_ptr;
    owner_nx   = owner;
    cnt_nx     = lock_cnt;
    timeout_nx = 1'b0;
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    idx        = 0;
    found      = 1'b0;

    if (!reset) begin
      // Nothing is granted while reset is held.
      state_nx = ST_ARB;
    end else if (test_en) begin
      state_nx = ST_TEST;
      cnt_nx   = '0;
    end else if (state == ST_LOCK) begin
      cnt_nx = lock_cnt + 1'b1;
      if (req[owner]) begin
        gnt_any = 1'b1;
        gnt_idx = owner;
      end
      if (!req[owner] || !req_lock[owner]) begin
        state_nx = ST_ARB;
        rr_nx    = inc_ptr(owner);
        cnt_nx   = '0;
      end else if (lock_cnt >= LAST_CNT) begin
        state_nx   = ST_ARB;
        rr_nx      = inc_ptr(owner);
        cnt_nx     = '0;
        timeout_nx = 1'b1;
      end
    end else begin
      // ARB, or TEST just released: arbitrate this cycle from the held pointer.
      state_nx = ST_ARB;
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req[idx]) begin
          found   = 1'b1;
          gnt_any = 1'b1;
          gnt_idx = IW'(idx);
        end
      end
      if (gnt_any) begin
        rr_nx = inc_ptr(gnt_idx);
        if (req_lock[gnt_idx]) begin
          state_nx = ST_LOCK;
          owner_nx = gnt_idx;
          cnt_nx   = CW'(1);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    gnt[gnt_idx] = gnt_any;
  end

  always_comb begin
    mem_waddr = '0;
    mem_raddr = '0;
    mem_din   = '0;
    mem_we    = 1'b0;
    if (reset && test_en) begin
      mem_waddr = test_waddr;
      mem_raddr = test_raddr;
      mem_din   = test_wdata;
      mem_we    = test_we;
    end else if (gnt_any) begin
      mem_waddr = req_addr[gnt_idx*AW +: AW];
      mem_raddr = req_addr[gnt_idx*AW +: AW];
      mem_din   = req_wdata[gnt_idx*DW +: DW];
      mem_we    = req_we[gnt_idx];
    end
  end

  assign rdata = mem_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_ARB;
      rr_ptr       <= '0;
      owner        <= '0;
      lock_cnt     <= '0;
      rvalid       <= '0;
      locked       <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nx;
      rr_ptr       <= rr_nx;
      owner        <= owner_nx;
      lock_cnt     <= cnt_nx;
      rvalid       <= gnt & ~req_we;
      locked       <= (state_nx == ST_LOCK);
      lock_timeout <= timeout_nx;
    end
  end

endmodule
